// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 line.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with filt_q
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver with scan-code FIFO and interrupt pulse.
// Define PS2_BREAK_FILTER_EN to drop break prefixes (F0) and the byte that follows.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          key_interrupt,
    output logic [7:0]                    scan_code,
    output logic                          code_valid,
    input  logic                          code_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic clk_f, data_f;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock    (clock),
        .reset    (reset),
        .line_in  (ps2_clk),
        .line_out (clk_f)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clock    (clock),
        .reset    (reset),
        .line_in  (ps2_data),
        .line_out (data_f)
    );

    logic clk_prev_q, clk_prev_d;
    logic fall;

    assign clk_prev_d = clk_f;
    assign fall       = clk_prev_q & ~clk_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    push_byte_q, push_byte_d;
    logic          ferr_q, ferr_d;
`ifdef PS2_BREAK_FILTER_EN
    logic          brk_q, brk_d;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        ferr_d      = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d       = brk_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall && !data_f) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    tmo_d     = TMO_LOAD;
                end
            end
            DATA: begin
                if (fall) begin
                    tmo_d     = TMO_LOAD;
                    shift_d   = {data_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    tmo_d    = TMO_LOAD;
                    par_ok_d = ^{data_f, shift_q};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                    if (par_ok_q && data_f) begin
`ifdef PS2_BREAK_FILTER_EN
                        if (shift_q == BREAK_PREFIX) begin
                            brk_d = 1'b1;
                        end else if (brk_q && shift_q != EXT_PREFIX) begin
                            brk_d = 1'b0;
                        end else begin
                            push_d      = 1'b1;
                            push_byte_d = shift_q;
                        end
`else
                        push_d      = 1'b1;
                        push_byte_d = shift_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // inactivity watchdog: any in-frame cycle without a clock fall counts down
        if (state_q != IDLE && !fall) begin
            if (tmo_q == '0) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ki_q, ki_d;
    logic          ovf_q, ovf_d;
    logic          pop, full, wr_en;

    // a pop frees the head slot in the same cycle, so a full FIFO still accepts the push
    always_comb begin
        pop      = code_ack && (count_q != '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        wr_en    = push_q && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_byte_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ki_d  = wr_en;
        ovf_d = push_q && full && !pop;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_byte_q <= 8'h00;
            ferr_q      <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= 1'b0;
`endif
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ki_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            ferr_q      <= ferr_d;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= brk_d;
`endif
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ki_q        <= ki_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_interrupt = ki_q;
    assign frame_err     = ferr_q;
    assign overflow      = ovf_q;
    assign fifo_count    = count_q;
    assign code_valid    = (count_q != '0);
    assign scan_code     = code_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: queue-based reference model, directed cases, random frames.
module tb_ps2_key_receiver;

    localparam int FD = 4;
    localparam int FL = 8;
    localparam int TO = 300;
    localparam int H  = 20;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 ps2_clk = 1'b1;
    logic                 ps2_data = 1'b1;
    logic                 code_ack = 1'b0;
    logic                 key_interrupt, code_valid, frame_err, overflow;
    logic [7:0]           scan_code;
    logic [$clog2(FD):0]  fifo_count;

    always #5 clock = ~clock;

    ps2_key_receiver #(
        .FIFO_DEPTH     (FD),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key_interrupt (key_interrupt),
        .scan_code     (scan_code),
        .code_valid    (code_valid),
        .code_ack      (code_ack),
        .fifo_count    (fifo_count),
        .frame_err     (frame_err),
        .overflow      (overflow)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_stop = 0;
    int lat    = 12;
    int last_ki_cyc = -1;
    int exp_ki = 0, exp_ferr = 0, exp_ovf = 0;
    int n_ki = 0, n_ferr = 0, n_ovf = 0;
    bit busy = 1'b1;
    bit brk_m = 1'b0;
    logic [7:0] model_q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // compare process: pulses are always tallied, state checked whenever no frame is in flight
    always @(posedge clock) begin
        #1;
        cyc++;
        if (key_interrupt) begin
            n_ki++;
            last_ki_cyc = cyc;
        end
        if (frame_err) n_ferr++;
        if (overflow)  n_ovf++;
        if (!busy) begin
            check("fifo_count", int'(fifo_count), model_q.size());
            check("code_valid", int'(code_valid), (model_q.size() != 0) ? 1 : 0);
            check("scan_code",  int'(scan_code),  (model_q.size() != 0) ? int'(model_q[0]) : 0);
            check("ki_pulses",   n_ki,   exp_ki);
            check("ferr_pulses", n_ferr, exp_ferr);
            check("ovf_pulses",  n_ovf,  exp_ovf);
        end
    end

    task automatic model_good(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
        if (b == 8'hF0) begin
            brk_m = 1'b1;
            return;
        end
        if (brk_m && b != 8'hE0) begin
            brk_m = 1'b0;
            return;
        end
`endif
        if (model_q.size() == FD) begin
            exp_ovf++;
        end else begin
            model_q.push_back(b);
            exp_ki++;
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit ack_w);
        logic par;
        busy = 1'b1;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = ~bad_stop;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b0;
        t_stop = cyc;
        for (int i = 0; i < H; i++) begin
            @(negedge clock);
            code_ack = ack_w && (cyc == t_stop + lat - 1);
        end
        code_ack = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (2 * H) @(negedge clock);
        if (bad_par || bad_stop) begin
            exp_ferr++;
        end else begin
            if (ack_w && model_q.size() != 0) void'(model_q.pop_front());
            model_good(b);
        end
        busy = 1'b0;
        @(negedge clock);
    endtask

    task automatic pop_one();
        code_ack = 1'b1;
        if (model_q.size() != 0) void'(model_q.pop_front());
        @(negedge clock);
        code_ack = 1'b0;
        @(negedge clock);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] v);
        check(name, int'(scan_code), int'(v));
        pop_one();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int r;

        repeat (5) @(negedge clock);
        check("rst_key_interrupt", int'(key_interrupt), 0);
        check("rst_code_valid",    int'(code_valid),    0);
        check("rst_scan_code",     int'(scan_code),     0);
        check("rst_fifo_count",    int'(fifo_count),    0);
        check("rst_frame_err",     int'(frame_err),     0);
        check("rst_overflow",      int'(overflow),      0);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        busy = 1'b0;

        // single good frame
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("good_count", int'(fifo_count), 1);
        check("good_scan",  int'(scan_code), 8'h1C);
        check("good_valid", int'(code_valid), 1);
        check("good_ki",    n_ki, 1);
        lat = last_ki_cyc - t_stop;
        check("latency_in_range", (lat >= 3 && lat <= H - 2) ? 1 : 0, 1);
        pop_one();

        // parity error
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check("par_ferr",  n_ferr, 1);
        check("par_count", int'(fifo_count), 0);
        check("par_ki",    n_ki, 1);

        // ack on empty FIFO
        pop_one();
        check("empty_ack_count", int'(fifo_count), 0);

        // overflow with five frames
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_pulse", n_ovf, 1);
        pop_expect("ovf_pop0", 8'h11);
        pop_expect("ovf_pop1", 8'h22);
        pop_expect("ovf_pop2", 8'h33);
        pop_expect("ovf_pop3", 8'h44);
        check("ovf_drained", int'(fifo_count), 0);

        // full FIFO with simultaneous ack on the write cycle
        send_frame(8'hA1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA2, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA4, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("fullack_count", int'(fifo_count), 4);
        check("fullack_no_ovf", n_ovf, 1);
        pop_expect("fullack_pop0", 8'hA2);
        pop_expect("fullack_pop1", 8'hA3);
        pop_expect("fullack_pop2", 8'hA4);
        pop_expect("fullack_pop3", 8'hA5);

        // timeout after start bit plus three data bits
        busy = 1'b1;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clock);
        exp_ferr++;
        busy = 1'b0;
        @(negedge clock);
        check("tmo_ferr", n_ferr, 2);
        send_frame(8'h32, 1'b0, 1'b0, 1'b0);
        check("tmo_next_scan", int'(scan_code), 8'h32);
        pop_one();

        // short glitches on both lines must not start a frame
        busy = 1'b1;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FL - 3) @(negedge clock);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clock);
        busy = 1'b0;
        @(negedge clock);
        check("glitch_ferr", n_ferr, 2);

        // break prefix handling
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        check("brk_count", int'(fifo_count), 1);
        pop_expect("brk_pop0", 8'h1C);
`else
        check("brk_count", int'(fifo_count), 3);
        pop_expect("brk_pop0", 8'h1C);
        pop_expect("brk_pop1", 8'hF0);
        pop_expect("brk_pop2", 8'h1C);
`endif

        // reset in the middle of a frame
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        busy = 1'b1;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        reset = 1'b0;
        model_q.delete();
        brk_m = 1'b0;
        repeat (4) @(negedge clock);
        check("midrst_count", int'(fifo_count), 0);
        check("midrst_valid", int'(code_valid), 0);
        reset = 1'b1;
        repeat (2 * H) @(negedge clock);
        busy = 1'b0;
        send_frame(8'h4B, 1'b0, 1'b0, 1'b0);
        check("midrst_scan", int'(scan_code), 8'h4B);
        check("midrst_count_after", int'(fifo_count), 1);
        pop_one();

        // randomized frames and pops
        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            if (r == 0) b = 8'hF0;
            if (r == 1) b = 8'hE0;
            send_frame(b, r == 2, r == 3, r == 4);
            repeat ($urandom_range(0, 2)) pop_one();
        end
        while (model_q.size() != 0) pop_one();
        pop_one();
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: scan-code FIFO entries; power of 2, minimum 2.
REQ-002 Parameter FILTER_LEN, default 8: consecutive equal samples required before a filtered PS/2 line changes.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: idle clock cycles inside a frame before the frame aborts.
REQ-004 clock  input  1  system clock; the single clock domain.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 ps2_clk  input  1  asynchronous PS/2 clock line from the keyboard.
REQ-007 ps2_data  input  1  asynchronous PS/2 data line from the keyboard.
REQ-008 key_interrupt  output  1  one-cycle pulse per byte enqueued; drives the processor key_interrupt input.
REQ-009 scan_code  output  8  byte at the FIFO head; 0 when empty.
REQ-010 code_valid  output  1  FIFO non-empty.
REQ-011 code_ack  input  1  pop request; acts only while code_valid=1.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored bytes.
REQ-013 frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout abort.
REQ-014 overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-015 Each PS/2 line SHALL pass through a 2-flop synchronizer, then a glitch filter; a filtered value changes only after FILTER_LEN consecutive equal synchronized samples.
REQ-016 A bit SHALL be sampled from filtered ps2_data on the cycle a falling edge of filtered ps2_clk is detected.
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, STOP.
- IDLE -> DATA on a sampled 0 (start bit); a sampled 1 is ignored.
- DATA: 8 bits, LSB first, then -> PARITY.
- PARITY -> STOP.
- STOP -> IDLE.
REQ-018 A frame SHALL be good only if data bits plus parity bit have odd parity and the stop bit is 1; otherwise frame_err pulses and nothing is enqueued.
REQ-019 In any state other than IDLE, TIMEOUT_CYCLES cycles with no falling edge SHALL force IDLE, pulse frame_err and discard the partial byte.
REQ-020 A good byte SHALL be written to the FIFO on the cycle after the stop-bit sample; code_valid, scan_code, fifo_count and key_interrupt update one cycle later.
REQ-021 A pop SHALL occur on any cycle with code_ack=1 and code_valid=1; the next entry appears the following cycle; code_ack while empty has no effect.
REQ-022 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; fifo_count is unchanged.
REQ-023 A push into a full FIFO with no pop SHALL drop the byte, pulse overflow, and not pulse key_interrupt.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 While reset=0 at a clock edge, the following SHALL be set:
- FSM to IDLE; bit, timeout and filter counters to 0.
- Synchronizers and filtered lines to 1.
- FIFO emptied.
- All outputs to 0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame; the first frame fully received after reset release is decoded normally.

Configuration
REQ-027 With macro PS2_BREAK_FILTER_EN defined:
- A good byte 8'hF0 is not enqueued and sets a break flag.
- The next good byte is also not enqueued and clears the flag.
- 8'hE0 is enqueued normally and does not affect the flag.
- The break flag clears on reset.
REQ-028 Without PS2_BREAK_FILTER_EN, every good byte SHALL be enqueued and no break flag SHALL exist.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state typedef and the constants for 8'hF0 (break prefix) and 8'hE0 (extended prefix).
REQ-030 Sub-module ps2_sync_filter (synchronizer plus glitch filter, parameter FILTER_LEN) SHALL be instantiated once per PS/2 line; the FIFO and FSM are inline.

Verification
REQ-031 Frame 0x1C with odd parity 0, stop 1 -> one key_interrupt pulse; scan_code=0x1C; code_valid=1; fifo_count=1.
REQ-032 Frame 0x1C with parity 1 -> frame_err pulses once; fifo_count stays 0; no key_interrupt.
REQ-033 5 good frames with FIFO_DEPTH=4 and no ack -> fifo_count=4; overflow pulses once; acks return the first 4 bytes in order.
REQ-034 Start bit then 3 data bits, then line idle for TIMEOUT_CYCLES -> frame_err pulses and FSM returns to IDLE; the next frame 0x32 is received correctly.
REQ-035 Bytes 0x1C, 0xF0, 0x1C sent -> with PS2_BREAK_FILTER_EN, FIFO holds only 0x1C; without it, FIFO holds 0x1C, 0xF0, 0x1C.
REQ-036 FIFO full and code_ack=1 on the cycle a good byte is written -> no overflow pulse; fifo_count stays 4; the new byte is at the tail.
